// File: rtl/count_stream_pkg.sv
// Shared types and defaults for the count stream decoder.
package count_stream_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned RUN_W         = 4;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        SYNC = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } dec_state_t;

endpackage

// File: rtl/step_classifier.sv
// Combinational classification of one count step (modulo 2^WIDTH).
module step_classifier
    import count_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count,
    output logic             is_up,
    output logic             is_down,
    output logic             is_hold,
    output logic             is_wrap
);

    logic [WIDTH-1:0] delta;

    // Modulo difference decides the step kind; wrap is a legal step across max<->0.
    always_comb begin
        delta   = count - prev;
        is_up   = (delta == WIDTH'(1));
        is_down = (delta == '1);
        is_hold = (delta == '0);
        is_wrap = (is_up && (prev == '1) && (count == '0)) ||
                  (is_down && (prev == '0) && (count == '1));
    end

endmodule

// File: rtl/count_stream_decoder.sv
// Reader/checker for an up/down counter bus: decodes direction, checks steps,
// tracks lock and counts illegal steps.
module count_stream_decoder
    import count_stream_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned LOCK_N = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] count,
    output logic [1:0]       dir,
    output logic             ud,
    output logic             wrap,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             locked
);

    localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_N);

    dec_state_t       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    dir_t             dir_q, dir_d;
    logic             ud_q, ud_d;
    logic             wrap_q, wrap_d;
    logic             serr_q, serr_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             locked_q, locked_d;
    logic [RUN_W-1:0] run_q, run_d;

    logic is_up, is_down, is_hold, is_wrap;

    step_classifier #(.WIDTH(WIDTH)) u_cls (
        .prev    (prev_q),
        .count   (count),
        .is_up   (is_up),
        .is_down (is_down),
        .is_hold (is_hold),
        .is_wrap (is_wrap)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ACQ;
        else      state_q <= state_d;
    end

    // Next state: first sample acquires, then each valid sample is classified.
    always_comb begin
        state_d = state_q;
        if (valid) begin
            if (state_q == ACQ)  state_d = SYNC;
            else if (is_up)      state_d = UP;
            else if (is_down)    state_d = DOWN;
            else if (!is_hold)   state_d = SYNC;
        end
    end

    // Next values of the registered outputs, lock run and error counter.
    always_comb begin
        prev_d   = prev_q;
        dir_d    = dir_q;
        ud_d     = ud_q;
        wrap_d   = 1'b0;
        serr_d   = 1'b0;
        err_d    = err_q;
        locked_d = locked_q;
        run_d    = run_q;
        if (valid) begin
            prev_d = count;
            if (state_q != ACQ) begin
                if (is_up) begin
                    // Run saturates at LOCK_N; a reversal or resync restarts it at 1.
                    run_d    = (state_q == UP) ? ((run_q < LOCK_V) ? run_q + 1'b1 : run_q)
                                               : RUN_W'(1);
                    dir_d    = DIR_UP;
                    ud_d     = 1'b1;
                    wrap_d   = is_wrap;
                    locked_d = (run_d >= LOCK_V);
                end else if (is_down) begin
                    run_d    = (state_q == DOWN) ? ((run_q < LOCK_V) ? run_q + 1'b1 : run_q)
                                                 : RUN_W'(1);
                    dir_d    = DIR_DOWN;
                    ud_d     = 1'b0;
                    wrap_d   = is_wrap;
                    locked_d = (run_d >= LOCK_V);
                end else if (!is_hold) begin
                    serr_d   = 1'b1;
                    err_d    = (err_q == '1) ? err_q : err_q + 1'b1;
                    dir_d    = DIR_NONE;
                    locked_d = 1'b0;
                    run_d    = '0;
                end
            end
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q   <= '0;
            dir_q    <= DIR_NONE;
            ud_q     <= 1'b0;
            wrap_q   <= 1'b0;
            serr_q   <= 1'b0;
            err_q    <= '0;
            locked_q <= 1'b0;
            run_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            dir_q    <= dir_d;
            ud_q     <= ud_d;
            wrap_q   <= wrap_d;
            serr_q   <= serr_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            run_q    <= run_d;
        end
    end

    assign dir      = dir_q;
    assign ud       = ud_q;
    assign wrap     = wrap_q;
    assign step_err = serr_q;
    assign err_cnt  = err_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_count_stream_decoder.sv
// Self-checking bench: directed sequences plus a random walk, compared each
// cycle against a behavioural model of the stream rules.
module tb_count_stream_decoder;

    localparam int LOCK_N = 2;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] count;
    logic [1:0] dir;
    logic       ud;
    logic       wrap;
    logic       step_err;
    logic [7:0] err_cnt;
    logic       locked;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int m_have, m_prev, m_dir, m_ud, m_run, m_err, m_locked, m_wrap, m_serr;

    count_stream_decoder #(.WIDTH(8), .LOCK_N(LOCK_N), .ERR_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .count    (count),
        .dir      (dir),
        .ud       (ud),
        .wrap     (wrap),
        .step_err (step_err),
        .err_cnt  (err_cnt),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_dir = 0; m_ud = 0; m_run = 0;
        m_err = 0; m_locked = 0; m_wrap = 0; m_serr = 0;
    endtask

    task automatic model_update(input int v, input int c);
        int d;
        m_wrap = 0;
        m_serr = 0;
        if (v == 0) return;
        if (m_have == 0) begin
            m_have = 1;
            m_prev = c;
            return;
        end
        d = (c - m_prev + 256) % 256;
        if (d == 1) begin
            m_wrap   = (m_prev == 255 && c == 0) ? 1 : 0;
            m_run    = (m_dir == 1) ? m_run + 1 : 1;
            m_dir    = 1;
            m_ud     = 1;
            m_locked = (m_run >= LOCK_N) ? 1 : 0;
        end else if (d == 255) begin
            m_wrap   = (m_prev == 0 && c == 255) ? 1 : 0;
            m_run    = (m_dir == 2) ? m_run + 1 : 1;
            m_dir    = 2;
            m_ud     = 0;
            m_locked = (m_run >= LOCK_N) ? 1 : 0;
        end else if (d != 0) begin
            m_serr   = 1;
            m_err    = (m_err < 255) ? m_err + 1 : 255;
            m_dir    = 0;
            m_run    = 0;
            m_locked = 0;
        end
        m_prev = c;
    endtask

    task automatic check_all();
        check("dir",      int'(dir),      m_dir);
        check("ud",       int'(ud),       m_ud);
        check("wrap",     int'(wrap),     m_wrap);
        check("step_err", int'(step_err), m_serr);
        check("err_cnt",  int'(err_cnt),  m_err);
        check("locked",   int'(locked),   m_locked);
        check("wrap_err_excl", int'(wrap & step_err), 0);
    endtask

    task automatic sample(input int v, input int c);
        @(negedge clk);
        valid = v[0];
        count = c[7:0];
        model_update(v, c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int wseq[7];
        int hseq[7];
        int cur;
        int trend;
        model_reset();
        rst   = 1'b0;
        valid = 1'b0;
        count = '0;
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Up ramp 0..24.
        for (int i = 0; i <= 24; i++) sample(1, i);
        check("ramp_up_locked", int'(locked), 1);
        check("ramp_up_ud", int'(ud), 1);

        // Down ramp 23..4.
        for (int i = 23; i >= 4; i--) sample(1, i);
        check("ramp_dn_ud", int'(ud), 0);
        check("ramp_dn_err", int'(err_cnt), 0);

        // Wrap sequence (entry from 4 to 254 is itself an illegal jump).
        wseq = '{254, 255, 0, 1, 1, 0, 255};
        foreach (wseq[i]) sample(1, wseq[i]);

        // Jump 10,11,14,15,16.
        sample(1, 10); sample(1, 11); sample(1, 14);
        check("jump_pulse", int'(step_err), 1);
        sample(1, 15); sample(1, 16);
        check("jump_relock", int'(locked), 1);

        // Gaps and holds; -1 marks a gap.
        hseq = '{5, 5, -1, 6, -1, 6, 7};
        foreach (hseq[i]) begin
            if (hseq[i] < 0) sample(0, $urandom_range(0, 255));
            else             sample(1, hseq[i]);
        end
        check("hold_locked", int'(locked), 1);

        // 300 illegal jumps drive err_cnt into saturation.
        for (int i = 0; i < 300; i++) sample(1, (i % 2 == 0) ? 100 : 0);
        check("err_sat", int'(err_cnt), 255);
        check("err_sat_pulse", int'(step_err), 1);

        // Asynchronous reset mid-stream, then re-acquire.
        apply_reset();
        sample(1, 77);
        sample(1, 78);
        sample(1, 79);

        // Random walk with persistent trend, holds, jumps and gaps.
        cur   = 79;
        trend = 1;
        for (int i = 0; i < 800; i++) begin
            int r;
            int v;
            v = ($urandom_range(0, 99) < 85) ? 1 : 0;
            if ($urandom_range(0, 19) == 0) trend = -trend;
            r = $urandom_range(0, 19);
            if (r < 14)      cur = (cur + trend + 256) % 256;
            else if (r < 18) cur = cur;
            else             cur = $urandom_range(0, 255);
            if (i == 400) apply_reset();
            sample(v, cur);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_stream_decoder.md
# count_stream_decoder

Receive-side companion to the 8-bit up/down counter. Samples the counter's `count` bus once per strobe and reconstructs the direction bit `ud`. Validates that every step is legal (+1, −1 or hold) and flags wrap-around and illegal jumps. Sits downstream of the counter as its reader and checker; outputs go to status/debug logic.

## Interface
- `WIDTH`, 8: width of the observed count bus.
- `LOCK_N`, 2: consecutive legal non-hold steps required before `locked` asserts (1..15).
- `ERR_W`, 8: width of the saturating error counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid`  in  1  sample strobe; `count` is sampled on this cycle.
- `count`  in  WIDTH  observed counter value.
- `dir`  out  2  decoded direction (`DIR_NONE`/`DIR_UP`/`DIR_DOWN`).
- `ud`  out  1  reconstructed direction bit: 1 up, 0 down; holds last decided value.
- `wrap`  out  1  one-cycle pulse: a legal step crossed max↔0.
- `step_err`  out  1  one-cycle pulse: illegal step detected.
- `err_cnt`  out  ERR_W  saturating count of illegal steps.
- `locked`  out  1  high while tracking a consistent stream.

## Operation
- States: `ACQ`, `SYNC`, `UP`, `DOWN`.
- Registered `prev` holds the last accepted sample.
- `delta = count − prev`, computed modulo 2^WIDTH.
- `ACQ` (after reset):
  - first `valid` loads `prev`, goes to `SYNC`.
  - no step is evaluated, so no error is possible.
- Classification of `delta` in `SYNC`/`UP`/`DOWN`, on every `valid`:
  - `delta == 1`: legal up step. Go to `UP`, `ud`=1, `dir`=`DIR_UP`.
  - `delta == all-ones`: legal down step. Go to `DOWN`, `ud`=0, `dir`=`DIR_DOWN`.
  - `delta == 0`: hold. State, `ud` and `dir` unchanged; the lock run counter neither increments nor clears.
  - otherwise: illegal step. `step_err` pulses, `err_cnt` increments (saturating at all-ones), state goes to `SYNC`, `dir`=`DIR_NONE`, `locked`=0, lock run cleared.
  - `prev` is loaded with `count` on every `valid`, including illegal steps (re-acquire on the new value).
- Direction reversal (`UP`↔`DOWN`) is legal. It does not pulse `step_err`, but the lock run restarts at 1, so `locked` drops until `LOCK_N` same-direction steps accrue.
- `wrap` pulses on:
  - an up step with `prev`=max and `count`=0;
  - a down step with `prev`=0 and `count`=max.
- `locked`:
  - asserts when the lock run reaches `LOCK_N`;
  - deasserts on an illegal step or a reversal.
- A counter reset seen as a jump to 0 (e.g. 12→0) is an illegal step by design.
- `valid` low: no state change; pulse outputs are 0.

## Timing
- All outputs are registered.
- Responses appear the cycle after the `valid` sample (latency 1).
- `wrap` and `step_err` are high for exactly one cycle per triggering sample.
- Back-to-back `valid` is supported: one sample per cycle, no stall.
- Reset values: state `ACQ`, `prev`=0, `dir`=`DIR_NONE`, `ud`=0, `wrap`=0, `step_err`=0, `err_cnt`=0, `locked`=0, lock run=0.
- Reset mid-stream clears everything immediately, independent of `clk`. The first `valid` after release only re-acquires.
- `step_err` and `wrap` are never high in the same cycle.
- `err_cnt` at saturation stays at all-ones; `step_err` still pulses.

## Structure
- Shared package `count_stream_pkg` contains:
  - `dir_t` (2-bit: `DIR_NONE`=0, `DIR_UP`=1, `DIR_DOWN`=2, 3 unused);
  - `dec_state_t` (`ACQ`, `SYNC`, `UP`, `DOWN`);
  - default `WIDTH`.
- One sub-module, `step_classifier`: combinational.
  - Inputs: `prev`, `count`.
  - Outputs: `is_up`, `is_down`, `is_hold`, `is_wrap`.
- FSM, lock run counter and saturating error counter live in the top module.

## Test plan
- Up ramp 0..24, `valid` every cycle: `dir`=UP and `ud`=1 from the 0→1 step; `locked` after 1→2; `err_cnt`=0; no `wrap`.
- Then down ramp 24→4: first down step drops `locked`; `locked` re-asserts after 23→22; `ud`=0; `err_cnt`=0.
- Wrap sequence 254,255,0,1, then 1,0,255: one `wrap` pulse after sample 0 (up), one after sample 255 (down); no errors.
- Jump 10,11,14,15,16: `step_err` pulses once after 14; `err_cnt`=1; `locked`=0 then re-asserts after 16.
- `valid` gaps and holds (5,5,_,6,_,6,7): no errors; `locked` after 7; holds do not break the run.
- 300 illegal jumps: `err_cnt` saturates at 255 and stays. `rst` low mid-stream: all outputs return to reset values immediately; the next sample re-acquires without error.
